// File: rtl/seq_fixmul.sv
// seq_fixmul: sequential signed fixed-point multiplier, Q(WIDTH-FRAC).FRAC.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   a, b      signed operands, sampled only on the accept edge (IDLE & start)
//   start     level request from the byte-serial shifter
//   z         registered signed result, held until the next FINISH
//   busy      high while a product is in progress
//   done      result valid, from completion until the next accept
//   overflow  registered with z; high when z was saturated
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; accepts operands on the first start edge
// CALC   | radix-2 shift-add on magnitudes, one multiplier bit per edge
// FINISH | rescale by FRAC, apply sign, saturate, publish result
// HOLD   | result held; waits for start to drop so one start = one product

module seq_fixmul #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    // Largest positive magnitude and largest negative magnitude that fit in WIDTH bits.
    localparam logic [2*WIDTH-1:0] POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   Z_POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   Z_NEG_SAT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mag;

    // |-2^(W-1)| wraps back to 2^(W-1), which is correct when read as unsigned.
    assign abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    // Truncating the magnitude rounds the signed result toward zero.
    assign mag = acc_q >> FRAC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            z_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        z_d      = z_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                // A zero magnitude falls through to z=0, overflow=0 on either sign.
                if (!sign_q) begin
                    if (mag > POS_MAX) begin
                        z_d   = Z_POS_SAT;
                        ovf_d = 1'b1;
                    end else begin
                        z_d   = mag[WIDTH-1:0];
                        ovf_d = 1'b0;
                    end
                end else begin
                    if (mag > NEG_MAX) begin
                        z_d   = Z_NEG_SAT;
                        ovf_d = 1'b1;
                    end else begin
                        z_d   = ~mag[WIDTH-1:0] + WIDTH'(1);
                        ovf_d = 1'b0;
                    end
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign z        = z_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
